// File: rtl/song_mcu.sv
// song_mcu: master control unit sequencing song_reader.
// It turns one-pulsed play/next/prev buttons and song_done into the play,
// song and reset_player controls. Every song change passes through a CLEAR
// phase, and the player then resumes or stays paused.
// Optional build macro SONG_MCU_REPEAT_EN adds the repeat_one input, which
// replays the current song when it ends.
module song_mcu #(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              auto_advance,
  input  logic              song_done,
`ifdef SONG_MCU_REPEAT_EN
  input  logic              repeat_one,
`endif
  output logic              play,
  output logic [SONG_W-1:0] song,
  output logic              reset_player,
  output logic              song_changed
);

  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t             state_r;
  logic               resume_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               repeat_s;

  // Next song index, wrapping from the last song back to 0.
  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
    if (s == SONG_W'(NUM_SONGS - 1)) begin
      return {SONG_W{1'b0}};
    end else begin
      return s + SONG_W'(1);
    end
  endfunction

  // Previous song index, wrapping from 0 to the last song.
  function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
    if (s == {SONG_W{1'b0}}) begin
      return SONG_W'(NUM_SONGS - 1);
    end else begin
      return s - SONG_W'(1);
    end
  endfunction

`ifdef SONG_MCU_REPEAT_EN
  assign repeat_s = repeat_one;
`else
  assign repeat_s = 1'b0;
`endif

  // Control FSM; all outputs are registered and updated with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= PAUSED;
      song         <= {SONG_W{1'b0}};
      play         <= 1'b0;
      reset_player <= 1'b0;
      song_changed <= 1'b0;
      resume_r     <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        PAUSED: begin
          song_changed <= 1'b0;
          if (next_button) begin
            song         <= song_inc(song);
            resume_r     <= 1'b0;
            state_r      <= CLEAR;
            reset_player <= 1'b1;
            song_changed <= 1'b1;
            cnt_r        <= CNT_W'(CLEAR_CYCLES - 1);
          end else if (prev_button) begin
            song         <= song_dec(song);
            resume_r     <= 1'b0;
            state_r      <= CLEAR;
            reset_player <= 1'b1;
            song_changed <= 1'b1;
            cnt_r        <= CNT_W'(CLEAR_CYCLES - 1);
          end else if (play_button) begin
            state_r <= PLAYING;
            play    <= 1'b1;
          end else begin
            state_r <= PAUSED;
          end
        end
        PLAYING: begin
          song_changed <= 1'b0;
          if (song_done) begin
            // Repeat replays the song; otherwise advance or rewind-and-pause.
            if (repeat_s) begin
              resume_r <= 1'b1;
            end else if (auto_advance) begin
              song     <= song_inc(song);
              resume_r <= 1'b1;
            end else begin
              resume_r <= 1'b0;
            end
            state_r      <= CLEAR;
            play         <= 1'b0;
            reset_player <= 1'b1;
            song_changed <= 1'b1;
            cnt_r        <= CNT_W'(CLEAR_CYCLES - 1);
          end else if (next_button) begin
            song         <= song_inc(song);
            resume_r     <= 1'b1;
            state_r      <= CLEAR;
            play         <= 1'b0;
            reset_player <= 1'b1;
            song_changed <= 1'b1;
            cnt_r        <= CNT_W'(CLEAR_CYCLES - 1);
          end else if (prev_button) begin
            song         <= song_dec(song);
            resume_r     <= 1'b1;
            state_r      <= CLEAR;
            play         <= 1'b0;
            reset_player <= 1'b1;
            song_changed <= 1'b1;
            cnt_r        <= CNT_W'(CLEAR_CYCLES - 1);
          end else if (play_button) begin
            // Pausing keeps the song position; the reader holds while play=0.
            state_r <= PAUSED;
            play    <= 1'b0;
          end else begin
            state_r <= PLAYING;
          end
        end
        CLEAR: begin
          song_changed <= 1'b0;
          if (cnt_r == {CNT_W{1'b0}}) begin
            reset_player <= 1'b0;
            play         <= resume_r;
            state_r      <= resume_r ? PLAYING : PAUSED;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r      <= PAUSED;
          play         <= 1'b0;
          reset_player <= 1'b0;
          song_changed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_mcu.sv
// Directed testbench for song_mcu (NUM_SONGS=4, SONG_W=2, CLEAR_CYCLES=2).
module tb_song_mcu;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, prev_button;
  logic       auto_advance, song_done;
`ifdef SONG_MCU_REPEAT_EN
  logic       repeat_one;
`endif
  logic       play;
  logic [1:0] song;
  logic       reset_player;
  logic       song_changed;

  int n_checks = 0;
  int n_fail   = 0;

  song_mcu #(.NUM_SONGS(4), .SONG_W(2), .CLEAR_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .auto_advance (auto_advance),
    .song_done    (song_done),
`ifdef SONG_MCU_REPEAT_EN
    .repeat_one   (repeat_one),
`endif
    .play         (play),
    .song         (song),
    .reset_player (reset_player),
    .song_changed (song_changed)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of button/song_done pulses, then release them.
  task automatic press(input logic p, input logic n, input logic v, input logic d);
    play_button = p;
    next_button = n;
    prev_button = v;
    song_done   = d;
    step();
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    song_done   = 1'b0;
  endtask

  // Called right after the edge that enters CLEAR; checks the 2-cycle clear.
  task automatic check_clear(input string tag, input logic [1:0] exp_song, input logic exp_play);
    check_eq({tag, "_rp0"}, reset_player, 1'b1);
    check_eq({tag, "_sc0"}, song_changed, 1'b1);
    check_eq({tag, "_song0"}, song, exp_song);
    check_eq({tag, "_play0"}, play, 1'b0);
    step();
    check_eq({tag, "_rp1"}, reset_player, 1'b1);
    check_eq({tag, "_sc1"}, song_changed, 1'b0);
    step();
    check_eq({tag, "_rp2"}, reset_player, 1'b0);
    check_eq({tag, "_play2"}, play, exp_play);
    check_eq({tag, "_song2"}, song, exp_song);
  endtask

  initial begin
    reset = 1'b1;
    play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
    auto_advance = 1'b0; song_done = 1'b0;
`ifdef SONG_MCU_REPEAT_EN
    repeat_one = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    check_eq("rst_play", play, 1'b0);
    check_eq("rst_song", song, 2'd0);
    check_eq("rst_rp", reset_player, 1'b0);
    check_eq("rst_sc", song_changed, 1'b0);

    // Play from reset: no clear pulse.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("play_on", play, 1'b1);
    check_eq("play_song", song, 2'd0);
    check_eq("play_rp", reset_player, 1'b0);
    step();
    check_eq("play_hold", play, 1'b1);
    check_eq("play_rp_hold", reset_player, 1'b0);

    // Pause, then prev from 0 wraps to 3 and stays paused.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pause_play", play, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check_clear("prev_wrap", 2'd3, 1'b0);

    // Paused next from 3 wraps to 0; prev returns to 3.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_clear("next_wrap", 2'd0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check_clear("prev_back", 2'd3, 1'b0);

    // Reach song 1 and start playing.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_clear("to0", 2'd0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_clear("to1", 2'd1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("play_s1", play, 1'b1);

    // Song end with auto-advance moves to song 2 and resumes.
    auto_advance = 1'b1;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check_clear("auto_adv", 2'd2, 1'b1);

    // Song end without auto-advance rewinds song 2 and pauses.
    auto_advance = 1'b0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check_clear("no_adv", 2'd2, 1'b0);

    // song_done ignored while paused.
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("pdone_rp", reset_player, 1'b0);
    check_eq("pdone_song", song, 2'd2);
    check_eq("pdone_play", play, 1'b0);

    // Playing: next + play same cycle, next wins; next during CLEAR ignored.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("play_s2", play, 1'b1);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("nxt_pri_rp", reset_player, 1'b1);
    check_eq("nxt_pri_sc", song_changed, 1'b1);
    check_eq("nxt_pri_song", song, 2'd3);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("clr_ign_song", song, 2'd3);
    check_eq("clr_ign_rp", reset_player, 1'b1);
    check_eq("clr_ign_sc", song_changed, 1'b0);
    step();
    check_eq("nxt_pri_exit_rp", reset_player, 1'b0);
    check_eq("nxt_pri_play", play, 1'b1);
    check_eq("nxt_pri_song_end", song, 2'd3);

    // Pause/resume keeps song and never clears.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pr_pause", play, 1'b0);
    check_eq("pr_song", song, 2'd3);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pr_resume", play, 1'b1);
    check_eq("pr_rp", reset_player, 1'b0);

    // Prev while playing resumes after clear.
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check_clear("prev_play", 2'd2, 1'b1);

    // song_done beats next: without auto-advance song stays, pauses.
    press(1'b0, 1'b1, 1'b0, 1'b1);
    check_clear("done_pri", 2'd2, 1'b0);

    // Reset on the first CLEAR cycle abandons the clear.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rc_rp_in", reset_player, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rc_play", play, 1'b0);
    check_eq("rc_song", song, 2'd0);
    check_eq("rc_rp", reset_player, 1'b0);
    check_eq("rc_sc", song_changed, 1'b0);
    step();
    check_eq("rc_rp_after", reset_player, 1'b0);
    check_eq("rc_play_after", play, 1'b0);

`ifdef SONG_MCU_REPEAT_EN
    // Repeat-one replays song 2 even with auto-advance on.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_clear("rep_to1", 2'd1, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    check_clear("rep_to2", 2'd2, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rep_play", play, 1'b1);
    repeat_one   = 1'b1;
    auto_advance = 1'b1;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check_clear("repeat", 2'd2, 1'b1);
    repeat_one = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
